// File: rtl/pcs_block_lock.sv
// pcs_block_lock: receive-side 64b/66b block synchroniser.
// Hunts for sync-header alignment and asks the gearbox to slip one bit on a bad header.
// Holds block lock until too many bad headers land in one test window.
// Forwards blocks to the decoder, one cycle late, only while locked.
// Optional hi-BER monitor: define PCS_HI_BER_EN to build it. Otherwise hi_ber is tied low.
module pcs_block_lock #(
  parameter int PCS_DATA_WIDTH    = 66,
  parameter int SH_CNT_MAX        = 64,
  parameter int SH_INVALID_MAX    = 16,
  parameter int SLIP_WAIT_BLOCKS  = 32,
  parameter int BER_WINDOW_BLOCKS = 19531
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PCS_DATA_WIDTH-1:0] encoded_data_in,
  input  logic                      encoded_valid_in,
  output logic [PCS_DATA_WIDTH-1:0] encoded_data_out,
  output logic                      encoded_valid_out,
  output logic                      slip_out,
  output logic                      block_lock,
  output logic [7:0]                sh_err_count,
  output logic                      hi_ber
);

  localparam int SH_W   = $clog2(SH_CNT_MAX) + 1;
  localparam int INV_W  = $clog2(SH_INVALID_MAX) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT_BLOCKS) + 1;

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_BLOCKS);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  state_t              state;
  logic [SH_W-1:0]     sh_cnt;
  logic [INV_W-1:0]    sh_invalid_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                valid_q;

  logic [1:0]          header;
  logic                sh_ok;
  logic                sh_bad;
  logic [SH_W-1:0]     sh_cnt_inc;
  logic [INV_W-1:0]    inv_inc;
  logic [WAIT_W-1:0]   wait_inc;

  // A header is valid only as 01 or 10, which is the same as its two bits differing.
  assign header     = encoded_data_in[PCS_DATA_WIDTH-1 -: 2];
  assign sh_ok      = ^header;
  assign sh_bad     = ~sh_ok;
  assign sh_cnt_inc = sh_cnt + SH_W'(1);
  assign inv_inc    = sh_invalid_cnt + INV_W'(sh_bad);
  assign wait_inc   = wait_cnt + WAIT_W'(1);

  // Datapath register: copy every valid block, and mark it for the decoder only if it arrived while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encoded_data_out <= '0;
      valid_q          <= 1'b0;
    end else begin
      valid_q <= encoded_valid_in && (state == LOCKED);
      if (encoded_valid_in) begin
        encoded_data_out <= encoded_data_in;
      end
    end
  end

  // A high error rate masks forwarding without disturbing the lock machine.
  assign encoded_valid_out = valid_q & ~hi_ber;

  // Lock state machine: only valid blocks advance it, and each slip request lasts a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      slip_out       <= 1'b0;
      block_lock     <= 1'b0;
      sh_err_count   <= '0;
    end else begin
      slip_out <= 1'b0;
      if (encoded_valid_in) begin
        case (state)
          HUNT: begin
            if (sh_ok) begin
              if (sh_cnt_inc == SH_LAST) begin
                state          <= LOCKED;
                block_lock     <= 1'b1;
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
              end else begin
                sh_cnt <= sh_cnt_inc;
              end
            end else begin
              slip_out <= 1'b1;
              sh_cnt   <= '0;
              wait_cnt <= '0;
              state    <= SLIP_WAIT;
            end
          end
          SLIP_WAIT: begin
            if (wait_inc == WAIT_LAST) begin
              state    <= HUNT;
              wait_cnt <= '0;
              sh_cnt   <= '0;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
          LOCKED: begin
            if (sh_bad && (sh_err_count != 8'hFF)) begin
              sh_err_count <= sh_err_count + 8'd1;
            end
            if (inv_inc == INV_LAST) begin
              state          <= SLIP_WAIT;
              block_lock     <= 1'b0;
              slip_out       <= 1'b1;
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
              wait_cnt       <= '0;
            end else if (sh_cnt_inc == SH_LAST) begin
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
            end else begin
              sh_cnt         <= sh_cnt_inc;
              sh_invalid_cnt <= inv_inc;
            end
          end
          default: begin
            state      <= HUNT;
            block_lock <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PCS_HI_BER_EN
  localparam int                BER_W      = $clog2(BER_WINDOW_BLOCKS) + 1;
  localparam logic [BER_W-1:0]  WIN_LAST   = BER_W'(BER_WINDOW_BLOCKS);
  localparam logic [BER_W-1:0]  BER_THRESH = BER_W'(16);

  logic [BER_W-1:0] win_cnt;
  logic [BER_W-1:0] ber_cnt;
  logic [BER_W-1:0] win_inc;
  logic [BER_W-1:0] ber_inc;
  logic             hi_ber_q;

  assign win_inc = win_cnt + BER_W'(1);
  assign ber_inc = ber_cnt + BER_W'(sh_bad);

  // BER monitor: count bad headers in every state and flag as soon as the window reaches the threshold.
  // At the end of each window, re-evaluate the flag from that window's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else if (encoded_valid_in) begin
      if (win_inc == WIN_LAST) begin
        hi_ber_q <= (ber_inc >= BER_THRESH);
        win_cnt  <= '0;
        ber_cnt  <= '0;
      end else begin
        win_cnt <= win_inc;
        ber_cnt <= ber_inc;
        if (ber_inc >= BER_THRESH) begin
          hi_ber_q <= 1'b1;
        end
      end
    end
  end

  assign hi_ber = hi_ber_q;
`else
  // Without the monitor the window length has no effect, and the flag is constant low.
  localparam logic BER_TIE_LOW = (BER_WINDOW_BLOCKS < 0);
  assign hi_ber = BER_TIE_LOW;
`endif

endmodule

// File: doc/pcs_block_lock.md
Name: pcs_block_lock

Overview:
- Receive-side block synchroniser and sequencer for the 64b/66b decoder.
- Sits between the RX gearbox, which produces 66-bit blocks, and the decoder.
- Runs the Clause 49 style lock state machine on the 2-bit sync header and issues slip requests to the gearbox.
- Forwards blocks to the decoder only while block lock is held.

Parameters:
- PCS_DATA_WIDTH, 66, width of one encoded block (sync header in bits [65:64]).
- SH_CNT_MAX, 64, blocks per sync-header test window.
- SH_INVALID_MAX, 16, invalid headers within one window that cause loss of lock.
- SLIP_WAIT_BLOCKS, 32, input blocks discarded after a slip while the gearbox realigns.
- BER_WINDOW_BLOCKS, 19531, hi-BER observation window in blocks (about 125 us at 156.25 Mblock/s); used only with the optional feature.

Ports:
- clk  input  1  block clock.
- rst  input  1  reset; asynchronous, active-high.
- encoded_data_in  input  PCS_DATA_WIDTH  block from the gearbox.
- encoded_valid_in  input  1  qualifies encoded_data_in.
- encoded_data_out  output  PCS_DATA_WIDTH  registered copy of encoded_data_in, to the decoder.
- encoded_valid_out  output  1  valid to the decoder; asserted only for blocks accepted while locked.
- slip_out  output  1  one-cycle pulse requesting the gearbox to shift alignment by one bit.
- block_lock  output  1  high while in LOCKED.
- sh_err_count  output  8  saturating count of invalid sync headers seen while locked; cleared only by reset.
- hi_ber  output  1  high bit-error-rate flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: asynchronous, active-high. While rst=1:
  - state=HUNT; sh_cnt=0; sh_invalid_cnt=0; wait_cnt=0.
  - All outputs are 0, including encoded_data_out and sh_err_count.
- Sync header rules:
  - sh_ok = (header==2'b01) or (header==2'b10).
  - 2'b00 and 2'b11 are invalid.
  - Only cycles with encoded_valid_in=1 are evaluated; idle cycles hold all state.
- Datapath:
  - Latency is 1 cycle.
  - encoded_data_out is loaded on every cycle with encoded_valid_in=1.
  - encoded_valid_out(next) = encoded_valid_in AND (state==LOCKED at arrival).
  - The block that causes loss of lock is still forwarded; the decoder flags its header.
  - The block that completes lock is not forwarded.
- HUNT state:
  - sh_ok block: sh_cnt+1. If the incremented value equals SH_CNT_MAX, then:
    - state goes to LOCKED and block_lock=1 from the next cycle;
    - sh_cnt and sh_invalid_cnt are cleared.
  - Invalid header: slip_out=1 for exactly the next cycle; sh_cnt cleared; state goes to SLIP_WAIT; wait_cnt cleared.
- SLIP_WAIT state:
  - Each valid block increments wait_cnt and is discarded.
  - When wait_cnt reaches SLIP_WAIT_BLOCKS, state goes to HUNT.
  - slip_out never asserts in this state.
- LOCKED state, per valid block:
  - sh_cnt+1.
  - Invalid header: sh_invalid_cnt+1 and sh_err_count+1, saturating at 255.
  - If sh_invalid_cnt reaches SH_INVALID_MAX: block_lock=0 and slip_out=1 on the next cycle; state goes to SLIP_WAIT; all counters cleared.
  - Otherwise, if sh_cnt reaches SH_CNT_MAX: sh_cnt and sh_invalid_cnt are cleared and the state stays LOCKED.
  - Simultaneous case: if the 64th block of a window is also the 16th invalid, loss of lock wins.
- Counter widths: sh_cnt is clog2(SH_CNT_MAX)+1 bits; sh_invalid_cnt is clog2(SH_INVALID_MAX)+1 bits; no wrap is possible.
- slip_out is never asserted on two consecutive cycles.
- Reset asserted mid-frame or mid-wait aborts immediately to the reset values; there is no pending slip.

Optional Feature:
- Macro: PCS_HI_BER_EN.
- When defined:
  - A window counter counts valid blocks up to BER_WINDOW_BLOCKS.
  - A ber_cnt counts invalid headers in any state.
  - If ber_cnt reaches 16 within a window, hi_ber=1 immediately (next cycle).
  - At window end, hi_ber is set to (ber_cnt>=16) and ber_cnt is cleared.
  - While hi_ber=1, encoded_valid_out is forced 0.
  - hi_ber does not affect block_lock.
- When undefined: no BER logic; hi_ber is constant 0.

Test Plan:
1. Reset, then 64 blocks with header 2'b01 → block_lock=1 one cycle after the 64th; first encoded_valid_out=1 is for the 65th block, at 1-cycle latency; slip_out stays 0.
2. In HUNT after 10 good blocks, a block with header 2'b11:
   - slip_out pulses for 1 cycle;
   - the next 32 valid blocks produce no valid_out and no slip;
   - then 64 good blocks → lock.
3. Locked, with 15 headers of 2'b00 spread over one 64-block window → block_lock stays 1; sh_err_count=15; counters reset at the window end; a further 15 invalid in the next window still holds lock.
4. Locked, with 16 invalid headers within one window → the 16th block is forwarded; block_lock=0 and slip_out=1 on the next cycle; state is SLIP_WAIT.
5. rst pulsed asynchronously mid-SLIP_WAIT and while locked → all outputs are 0 immediately; recovery requires a full 64 good blocks.
6. With PCS_HI_BER_EN, BER_WINDOW_BLOCKS=100 and 16 invalid headers in 100 blocks → hi_ber=1 and encoded_valid_out suppressed; the next window has 0 invalid → hi_ber=0 at its end.
